// File: rtl/vec_checker.sv
// Exhaustive-sweep response checker: walks every IN_W-bit pattern, samples dut_out
// after SETTLE cycles and scores it against TRUTH. Optional macro: STOP_ON_FAIL_EN.
module vec_checker #(
   parameter int                     IN_W   = 3,
   parameter logic [(1<<IN_W)-1:0]   TRUTH  = 8'hE8,
   parameter int                     SETTLE = 2,
   parameter int                     CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              dut_out,
   output logic [IN_W-1:0]   pat_out,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [CNT_W-1:0]  err_cnt,
   output logic              fail_seen,
   output logic [IN_W-1:0]   first_fail
);

   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} stateT;

   typedef struct packed {
      logic [CNT_W-1:0] errCnt;
      logic             failSeen;
      logic [IN_W-1:0]  firstFail;
   } resultT;

   stateT           state, stateN;
   logic [SW-1:0]   settleCnt, settleCntN;
   logic [IN_W-1:0] patQ, patN;
   resultT          resQ, resN;
   logic            busyQ, doneQ, passQ;
   logic            busyN, doneN, passN;
   logic            mismatch, stopNow;

   assign mismatch = (dut_out != TRUTH[patQ]);

`ifdef STOP_ON_FAIL_EN
   assign stopNow = mismatch;
`else
   assign stopNow = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         settleCnt <= '0;
         patQ      <= '0;
         resQ      <= '0;
         busyQ     <= 1'b0;
         doneQ     <= 1'b0;
         passQ     <= 1'b0;
      end else begin
         state     <= stateN;
         settleCnt <= settleCntN;
         patQ      <= patN;
         resQ      <= resN;
         busyQ     <= busyN;
         doneQ     <= doneN;
         passQ     <= passN;
      end
   end

   always_comb begin
      stateN     = state;
      settleCntN = settleCnt;
      patN       = patQ;
      resN       = resQ;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               patN       = '0;
               resN       = '0;
               settleCntN = SW'(SETTLE - 1);
               stateN     = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (settleCnt == '0) stateN = ST_SAMPLE;
            else                 settleCntN = settleCnt - SW'(1);
         end
         ST_SAMPLE: begin
            if (mismatch) begin
               if (resQ.errCnt != '1) resN.errCnt = resQ.errCnt + CNT_W'(1);
               if (!resQ.failSeen) begin
                  resN.failSeen  = 1'b1;
                  resN.firstFail = patQ;
               end
            end
            // Terminal pattern ends the sweep; pat_out is never wrapped.
            if (patQ == '1 || stopNow) begin
               stateN = ST_DONE;
            end else begin
               patN       = patQ + IN_W'(1);
               settleCntN = SW'(SETTLE - 1);
               stateN     = ST_SETTLE;
            end
         end
         default: stateN = ST_IDLE;
      endcase
      busyN = (stateN == ST_SETTLE) || (stateN == ST_SAMPLE);
      doneN = (stateN == ST_DONE);
      passN = doneN && (resN.errCnt == '0);
   end

   assign pat_out    = patQ;
   assign busy       = busyQ;
   assign done       = doneQ;
   assign pass       = passQ;
   assign err_cnt    = resQ.errCnt;
   assign fail_seen  = resQ.failSeen;
   assign first_fail = resQ.firstFail;

endmodule

// File: tb/tb_vec_checker.sv
// Directed bench for vec_checker: a reference model pushes expected sweep results
// into a queue at each start; they are popped and checked when done rises.
module tb_vec_checker;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic       start2 = 1'b0;
   logic [1:0] mode = 2'd0;

   logic [2:0] patOut, firstFail;
   logic       busy, done, pass, failSeen, dutOut;
   logic [7:0] errCnt;

   logic [2:0] pat2, first2;
   logic       busy2, done2, pass2, fail2, dutOut2;
   logic [1:0] err2;

   logic [2:0] pat80, first80;
   logic       busy80, done80, pass80, fail80, dutOut80;
   logic [7:0] err80;

   int passCnt = 0, totalCnt = 0, failCnt = 0;

   typedef struct {
      int err; int ff; bit fs; bit ps; int pat; int cyc;
   } expT;
   expT q[$];

   always #5 clk = ~clk;

   function automatic logic maj(input logic [2:0] v);
      return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
   endfunction

   // mode 0: majority gate, 1: stuck-at-0, 2: inverted majority
   assign dutOut   = (mode == 2'd0) ? maj(patOut) : (mode == 2'd1) ? 1'b0 : ~maj(patOut);
   assign dutOut2  = ~maj(pat2);
   assign dutOut80 = &pat80;

   vec_checker dut (
      .clk(clk), .rst_n(rst_n), .start(start), .dut_out(dutOut),
      .pat_out(patOut), .busy(busy), .done(done), .pass(pass),
      .err_cnt(errCnt), .fail_seen(failSeen), .first_fail(firstFail)
   );

   vec_checker #(.CNT_W(2)) dutSat (
      .clk(clk), .rst_n(rst_n), .start(start2), .dut_out(dutOut2),
      .pat_out(pat2), .busy(busy2), .done(done2), .pass(pass2),
      .err_cnt(err2), .fail_seen(fail2), .first_fail(first2)
   );

   vec_checker #(.TRUTH(8'h80)) dutAnd (
      .clk(clk), .rst_n(rst_n), .start(start), .dut_out(dutOut80),
      .pat_out(pat80), .busy(busy80), .done(done80), .pass(pass80),
      .err_cnt(err80), .fail_seen(fail80), .first_fail(first80)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      totalCnt++;
      assert (obs === exp) passCnt++;
      else begin
         failCnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic expT model(input int m, input logic [7:0] tt, input int cmax);
      expT e;
      logic g;
      logic [2:0] v;
      e.err = 0; e.ff = 0; e.fs = 0; e.pat = 7; e.cyc = 24;
      for (int p = 0; p < 8; p++) begin
         v = 3'(p);
         g = (m == 0) ? maj(v) : (m == 1) ? 1'b0 : ~maj(v);
         if (g != tt[p]) begin
            if (!e.fs) begin e.fs = 1; e.ff = p; end
            if (e.err < cmax) e.err++;
`ifdef STOP_ON_FAIL_EN
            e.pat = p; e.cyc = 3 * (p + 1);
            break;
`endif
         end
      end
      e.ps = (e.err == 0);
      return e;
   endfunction

   task automatic checkZero(input string nm);
      chk({nm, " pat"}, patOut, 0);
      chk({nm, " busy"}, busy, 0);
      chk({nm, " done"}, done, 0);
      chk({nm, " pass"}, pass, 0);
      chk({nm, " err"}, errCnt, 0);
      chk({nm, " failSeen"}, failSeen, 0);
      chk({nm, " firstFail"}, firstFail, 0);
   endtask

   task automatic runSweep(input string nm, input logic [1:0] m, input int pokeAt);
      expT e;
      int k;
      bit gotDone;
      mode = m;
      q.push_back(model(int'(m), 8'hE8, 255));
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      k = 0; gotDone = 0;
      while (!gotDone && k < 60) begin
         if (done) gotDone = 1;
         else begin
            if (k == 0) begin
               chk({nm, " cleared err"}, errCnt, 0);
               chk({nm, " cleared failSeen"}, failSeen, 0);
               chk({nm, " cleared firstFail"}, firstFail, 0);
            end
            chk($sformatf("%s busy k%0d", nm, k), busy, 1);
            chk($sformatf("%s pat k%0d", nm, k), patOut, k / 3);
            if (k == pokeAt) start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            k++;
         end
      end
      chk({nm, " done reached"}, gotDone, 1);
      e = q.pop_front();
      chk({nm, " cycles"}, k, e.cyc);
      chk({nm, " busy"}, busy, 0);
      chk({nm, " err"}, errCnt, e.err);
      chk({nm, " firstFail"}, firstFail, e.ff);
      chk({nm, " failSeen"}, failSeen, e.fs);
      chk({nm, " pass"}, pass, e.ps);
      chk({nm, " pat"}, patOut, e.pat);
   endtask

   initial begin
      expT e;
      int k;
      #2 rst_n = 1'b0;
      #1 checkZero("reset");
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         chk("idle pat", patOut, 0);
         chk("idle busy", busy, 0);
      end

      runSweep("clean", 2'd0, -1);
      chk("and done", done80, 1);
      chk("and pass", pass80, 1);
      chk("and err", err80, 0);
      chk("and failSeen", fail80, 0);

      runSweep("stuck0", 2'd1, -1);
      @(posedge clk); #1;
      runSweep("stuck0 again", 2'd1, -1);

      #3 rst_n = 1'b0;
      #1 checkZero("midclk reset");
      @(negedge clk) rst_n = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
         chk("post reset pat", patOut, 0);
         chk("post reset busy", busy, 0);
         chk("post reset done", done, 0);
      end

      runSweep("ignored start", 2'd0, 12);

      mode = 2'd0;
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      k = 0;
      while (patOut != 3'd5 && k < 40) begin
         @(posedge clk); #1;
         k++;
      end
      chk("abort reached pat5", patOut, 5);
      #3 rst_n = 1'b0;
      #1 checkZero("abort reset");
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("abort idle pat", patOut, 0);
      chk("abort idle busy", busy, 0);
      chk("abort idle done", done, 0);

      q.push_back(model(2, 8'hE8, 3));
      start2 = 1'b1;
      @(posedge clk); #1 start2 = 1'b0;
      k = 0;
      while (!done2 && k < 60) begin
         @(posedge clk); #1;
         k++;
      end
      e = q.pop_front();
      chk("sat done", done2, 1);
      chk("sat cycles", k, e.cyc);
      chk("sat err", err2, e.err);
      chk("sat firstFail", first2, e.ff);
      chk("sat failSeen", fail2, e.fs);
      chk("sat pass", pass2, e.ps);
      chk("sat pat", pat2, e.pat);

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
